// File: rtl/retire_trace_capture_if.sv
// Trace record stream from the retirement monitor to a host/UART dumper.
// A record transfers on any rising edge where trace_valid and trace_ready are both 1;
// while trace_valid=1 and trace_ready=0 every payload signal holds stable.
interface retire_trace_capture_if;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic [31:0] trace_instr;
  logic        trace_wen;
  logic [4:0]  trace_waddr;
  logic [31:0] trace_wdata;

  modport master (
    output trace_valid, trace_pc, trace_instr, trace_wen, trace_waddr, trace_wdata,
    input  trace_ready
  );

  modport slave (
    input  trace_valid, trace_pc, trace_instr, trace_wen, trace_waddr, trace_wdata,
    output trace_ready
  );
endinterface

// File: rtl/retire_trace_capture.sv
// Retirement monitor: detects instruction boundaries on the core IR, packs
// {pc, instr, last reg write} into a record and buffers it for a stream consumer.
module retire_trace_capture #(
  parameter int          DEPTH     = 16,
  parameter logic [31:0] PC_OFFSET = 32'd8,
  parameter int          CNT_W     = 16,
  localparam int         AW        = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     capture_en,
  input  logic [31:0]              ir_out,
  input  logic [31:0]              pc_out,
  input  logic                     rf_we,
  input  logic [4:0]               rf_waddr,
  input  logic [31:0]              rf_wdata,
  retire_trace_capture_if.master   trace,
  output logic [AW:0]              fifo_level,
  output logic [CNT_W-1:0]         drop_cnt
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } rec_t;

  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [31:0]      r_prev_instr;
  logic             r_acc_wen;
  logic [4:0]       r_acc_waddr;
  logic [31:0]      r_acc_wdata;
  rec_t             r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_level;
  logic [CNT_W-1:0] r_drop;

  logic w_bnd, w_wr, w_push, w_pop, w_full, w_valid, w_accept, w_drop;
  rec_t w_rec, w_head;

  assign w_bnd    = (ir_out != r_prev_instr);
  assign w_wr     = rf_we && (rf_waddr != 5'd0);
  assign w_full   = (r_level == FULL_LVL);
  assign w_valid  = (r_level != '0);
  assign w_push   = w_bnd && capture_en;
  assign w_pop    = w_valid && trace.trace_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_accept = w_push && (!w_full || w_pop);
  assign w_drop   = w_push && w_full && !w_pop;

  // The same-cycle write closes out the current record and wins over the accumulator.
  always_comb begin
    w_rec       = '0;
    w_rec.pc    = pc_out - PC_OFFSET;
    w_rec.instr = r_prev_instr;
    w_rec.wen   = w_wr || r_acc_wen;
    w_rec.waddr = w_wr ? rf_waddr : r_acc_waddr;
    w_rec.wdata = w_wr ? rf_wdata : r_acc_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev_instr <= '0;
      r_acc_wen    <= 1'b0;
      r_acc_waddr  <= '0;
      r_acc_wdata  <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_level      <= '0;
      r_drop       <= '0;
    end else begin
      if (w_bnd) begin
        r_prev_instr <= ir_out;
        r_acc_wen    <= 1'b0;
        r_acc_waddr  <= '0;
        r_acc_wdata  <= '0;
      end else if (w_wr) begin
        r_acc_wen    <= 1'b1;
        r_acc_waddr  <= rf_waddr;
        r_acc_wdata  <= rf_wdata;
      end
      if (w_accept) r_wptr <= r_wptr + 1'b1;
      if (w_pop)    r_rptr <= r_rptr + 1'b1;
      case ({w_accept, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_drop && (r_drop != '1)) r_drop <= r_drop + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && !reset) r_mem[r_wptr] <= w_rec;
  end

  // Payload is forced to zero while empty so stale entries never leak out.
  assign w_head            = w_valid ? r_mem[r_rptr] : '0;
  assign trace.trace_valid = w_valid;
  assign trace.trace_pc    = w_head.pc;
  assign trace.trace_instr = w_head.instr;
  assign trace.trace_wen   = w_head.wen;
  assign trace.trace_waddr = w_head.waddr;
  assign trace.trace_wdata = w_head.wdata;
  assign fifo_level        = r_level;
  assign drop_cnt          = r_drop;

endmodule

// File: tb/tb_retire_trace_capture.sv
// Directed bench for retire_trace_capture: boundaries, write merging, overflow,
// full push/pop, capture disable and mid-run reset.
module tb_retire_trace_capture;

  logic        clk;
  logic        reset;
  logic        capture_en;
  logic [31:0] ir_out;
  logic [31:0] pc_out;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  fifo_level;
  logic [15:0] drop_cnt;

  int checks;
  int errors;

  retire_trace_capture_if tif ();

  retire_trace_capture #(.DEPTH(16), .PC_OFFSET(32'd8), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .capture_en (capture_en),
    .ir_out     (ir_out),
    .pc_out     (pc_out),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .trace      (tif.master),
    .fifo_level (fifo_level),
    .drop_cnt   (drop_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                          input logic wen, input logic [4:0] waddr, input logic [31:0] wdata);
    chk({tag, ".valid"}, {31'd0, tif.trace_valid}, 32'd1);
    chk({tag, ".pc"},    tif.trace_pc, pc);
    chk({tag, ".instr"}, tif.trace_instr, instr);
    chk({tag, ".wen"},   {31'd0, tif.trace_wen}, {31'd0, wen});
    chk({tag, ".waddr"}, {27'd0, tif.trace_waddr}, {27'd0, waddr});
    chk({tag, ".wdata"}, tif.trace_wdata, wdata);
  endtask

  task automatic pop_one();
    tif.trace_ready = 1'b1;
    step();
    tif.trace_ready = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    capture_en = 1'b1;
    ir_out = '0;
    pc_out = '0;
    rf_we = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    tif.trace_ready = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    chk("rst.valid", {31'd0, tif.trace_valid}, 32'd0);
    chk("rst.level", {27'd0, fifo_level}, 32'd0);
    chk("rst.drop",  {16'd0, drop_cnt}, 32'd0);
    chk("rst.pc",    tif.trace_pc, 32'd0);
    chk("rst.instr", tif.trace_instr, 32'd0);
    chk("rst.wen",   {31'd0, tif.trace_wen}, 32'd0);
    chk("rst.waddr", {27'd0, tif.trace_waddr}, 32'd0);
    chk("rst.wdata", tif.trace_wdata, 32'd0);

    // First boundary records instr 0
    ir_out = 32'h2008_0005;
    pc_out = 32'h0000_000C;
    #1;
    chk("first.pre_valid", {31'd0, tif.trace_valid}, 32'd0);
    step();
    chk("first.level", {27'd0, fifo_level}, 32'd1);
    chk_head("first", 32'h4, 32'h0, 1'b0, 5'd0, 32'd0);

    // $8=5 two cycles before the next boundary
    rf_we = 1'b1; rf_waddr = 5'd8; rf_wdata = 32'd5;
    step();
    rf_we = 1'b0;
    step();
    ir_out = 32'h0108_4020;
    pc_out = 32'h10;
    step();
    chk("wr8.level", {27'd0, fifo_level}, 32'd2);
    chk_head("first_again", 32'h4, 32'h0, 1'b0, 5'd0, 32'd0);
    pop_one();
    chk_head("wr8", 32'h8, 32'h2008_0005, 1'b1, 5'd8, 32'd5);
    pop_one();
    chk("wr8.empty", {27'd0, fifo_level}, 32'd0);

    // $0 write ignored; same-cycle $9 write closes the record
    rf_we = 1'b1; rf_waddr = 5'd0; rf_wdata = 32'hDEAD;
    step();
    rf_waddr = 5'd9; rf_wdata = 32'hA;
    ir_out = 32'h1111_1111; pc_out = 32'h20;
    step();
    rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0;
    ir_out = 32'h2222_2222; pc_out = 32'h30;
    step();
    chk("wr9.level", {27'd0, fifo_level}, 32'd2);
    chk_head("wr9", 32'h18, 32'h0108_4020, 1'b1, 5'd9, 32'hA);
    pop_one();
    chk_head("after_wr9", 32'h28, 32'h1111_1111, 1'b0, 5'd0, 32'd0);
    pop_one();

    // capture_en=0: no push, accumulator still cleared at the boundary
    rf_we = 1'b1; rf_waddr = 5'd5; rf_wdata = 32'd7;
    step();
    rf_we = 1'b0;
    capture_en = 1'b0;
    ir_out = 32'h3333_3333; pc_out = 32'h40;
    step();
    chk("nocap.level", {27'd0, fifo_level}, 32'd0);
    chk("nocap.valid", {31'd0, tif.trace_valid}, 32'd0);
    capture_en = 1'b1;
    ir_out = 32'h4444_4444; pc_out = 32'h50;
    step();
    chk_head("nocap_next", 32'h48, 32'h3333_3333, 1'b0, 5'd0, 32'd0);
    pop_one();

    // Overflow: 20 boundaries, ready low
    for (int i = 0; i < 20; i++) begin
      ir_out = 32'h1000 + 32'(i);
      pc_out = 32'h100 + 32'(4 * i);
      step();
      chk($sformatf("fill%0d.level", i), {27'd0, fifo_level}, (i < 16) ? 32'(i + 1) : 32'd16);
      chk($sformatf("fill%0d.drop", i), {16'd0, drop_cnt}, (i < 16) ? 32'd0 : 32'(i - 15));
      chk($sformatf("fill%0d.head_pc", i), tif.trace_pc, 32'hF8);
      chk($sformatf("fill%0d.head_instr", i), tif.trace_instr, 32'h4444_4444);
    end

    // Full with simultaneous pop and push
    tif.trace_ready = 1'b1;
    ir_out = 32'h2000; pc_out = 32'h200;
    step();
    tif.trace_ready = 1'b0;
    chk("fullpp.level", {27'd0, fifo_level}, 32'd16);
    chk("fullpp.drop", {16'd0, drop_cnt}, 32'd4);

    // Drain 16 in order; the simultaneously pushed record is last
    for (int k = 1; k < 16; k++) begin
      chk_head($sformatf("drain%0d", k), 32'hF8 + 32'(4 * k), 32'h1000 + 32'(k - 1), 1'b0, 5'd0, 32'd0);
      pop_one();
    end
    chk_head("drain_last", 32'h1F8, 32'h1013, 1'b0, 5'd0, 32'd0);
    pop_one();
    chk("drain.level", {27'd0, fifo_level}, 32'd0);
    chk("drain.valid", {31'd0, tif.trace_valid}, 32'd0);

    // Mid-run reset discards buffered records
    ir_out = 32'h5000; pc_out = 32'h60;
    step();
    ir_out = 32'h5001;
    step();
    ir_out = 32'h5002;
    step();
    chk("prerst.level", {27'd0, fifo_level}, 32'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst.valid", {31'd0, tif.trace_valid}, 32'd0);
    chk("midrst.level", {27'd0, fifo_level}, 32'd0);
    chk("midrst.drop",  {16'd0, drop_cnt}, 32'd0);
    chk("midrst.pc",    tif.trace_pc, 32'd0);
    pc_out = 32'h70;
    step();
    chk("postrst.level", {27'd0, fifo_level}, 32'd1);
    chk_head("postrst", 32'h68, 32'h0, 1'b0, 5'd0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
